// File: rtl/chip8_alu_sequencer_pkg.sv
// chip8_alu_sequencer_pkg
// Shared types and constants for the CHIP-8 8XYN arithmetic sequencer:
//   ALU_f        - ALU function select (also used by the Chip8 ALU)
//   seq_state_t  - sequencer FSM states
//   flag_rule_t  - how the VF flag is derived from an operation
//   N_*          - N-nibble codes of the 8XYN instruction group
//   calc_flag()  - flag derivation from the 16-bit ALU result
package chip8_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_f_OR,
    ALU_f_AND,
    ALU_f_XOR,
    ALU_f_ADD,
    ALU_f_MINUS,
    ALU_f_RSHIFT,
    ALU_f_LSHIFT
  } ALU_f;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_X,
    S_RD_Y,
    S_EXEC,
    S_WB_X,
    S_WB_F,
    S_DONE
  } seq_state_t;

  typedef enum logic [2:0] {
    FLAG_NONE,
    FLAG_CARRY,
    FLAG_NO_BORROW,
    FLAG_VX_LSB,
    FLAG_VX_MSB,
    FLAG_ZERO
  } flag_rule_t;

  localparam logic [3:0] N_LD   = 4'h0;
  localparam logic [3:0] N_OR   = 4'h1;
  localparam logic [3:0] N_AND  = 4'h2;
  localparam logic [3:0] N_XOR  = 4'h3;
  localparam logic [3:0] N_ADD  = 4'h4;
  localparam logic [3:0] N_SUB  = 4'h5;
  localparam logic [3:0] N_SHR  = 4'h6;
  localparam logic [3:0] N_SUBN = 4'h7;
  localparam logic [3:0] N_SHL  = 4'hE;

  // Operands are zero-extended bytes, so bit 8 is the carry of an add and
  // bit 15 is the sign (borrow) of a subtract.
  function automatic logic calc_flag(input flag_rule_t rule,
                                     input logic [15:0] alu_out,
                                     input logic [7:0]  vx);
    logic f;
    case (rule)
      FLAG_CARRY:     f = alu_out[8];
      FLAG_NO_BORROW: f = ~alu_out[15];
      FLAG_VX_LSB:    f = vx[0];
      FLAG_VX_MSB:    f = vx[7];
      default:        f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/chip8_alu_sequencer_if.sv
// chip8_alu_sequencer_if
// Bundles the three buses the sequencer talks to:
//   CPU side : start, opcode_n, x_idx, y_idx -> busy, done, illegal
//   V-regs   : reg_addr, reg_we, reg_wdata -> reg_rdata (one-cycle read latency)
//   ALU      : alu_in1, alu_in2, alu_sel -> alu_out, alu_carry
// master = the sequencer, slave = the surrounding CPU / register file / ALU.
interface chip8_alu_sequencer_if;
  import chip8_alu_sequencer_pkg::*;

  logic        start;
  logic [3:0]  opcode_n;
  logic [3:0]  x_idx;
  logic [3:0]  y_idx;
  logic        busy;
  logic        done;
  logic        illegal;

  logic [3:0]  reg_addr;
  logic [7:0]  reg_rdata;
  logic        reg_we;
  logic [7:0]  reg_wdata;

  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  ALU_f        alu_sel;
  logic [15:0] alu_out;
  logic        alu_carry;

  modport master (
    input  start, opcode_n, x_idx, y_idx, reg_rdata, alu_out, alu_carry,
    output busy, done, illegal, reg_addr, reg_we, reg_wdata,
           alu_in1, alu_in2, alu_sel
  );

  modport slave (
    output start, opcode_n, x_idx, y_idx, reg_rdata, alu_out, alu_carry,
    input  busy, done, illegal, reg_addr, reg_we, reg_wdata,
           alu_in1, alu_in2, alu_sel
  );

endinterface

// File: rtl/chip8_alu_op_decode.sv
// chip8_alu_op_decode
// Purely combinational decode of the 8XYN N nibble.
// Ports:
//   i_n              - N nibble
//   o_alu_sel        - ALU function
//   o_swap_operands  - in1 takes Vy (and in2 takes Vx unless constant)
//   o_in2_is_const   - in2 takes o_in2_const instead of a register
//   o_in2_const      - constant operand value
//   o_flag_rule      - how VF is derived
//   o_writes_flag    - operation writes VF after Vx
//   o_illegal        - N not in {0-7, E}
// Build option: CHIP8_VF_RESET_EN makes OR/AND/XOR also clear VF.
module chip8_alu_op_decode
  import chip8_alu_sequencer_pkg::*;
(
  input  logic [3:0] i_n,
  output ALU_f       o_alu_sel,
  output logic       o_swap_operands,
  output logic       o_in2_is_const,
  output logic [7:0] o_in2_const,
  output flag_rule_t o_flag_rule,
  output logic       o_writes_flag,
  output logic       o_illegal
);

  always_comb begin
    o_alu_sel       = ALU_f_OR;
    o_swap_operands = 1'b0;
    o_in2_is_const  = 1'b0;
    o_in2_const     = 8'h00;
    o_flag_rule     = FLAG_NONE;
    o_writes_flag   = 1'b0;
    o_illegal       = 1'b0;
    case (i_n)
      // Vy | 0 moves Vy into Vx through the ALU
      N_LD: begin
        o_swap_operands = 1'b1;
        o_in2_is_const  = 1'b1;
      end
      N_OR, N_AND, N_XOR: begin
        o_alu_sel = (i_n == N_OR)  ? ALU_f_OR  :
                    (i_n == N_AND) ? ALU_f_AND : ALU_f_XOR;
`ifdef CHIP8_VF_RESET_EN
        o_flag_rule   = FLAG_ZERO;
        o_writes_flag = 1'b1;
`endif
      end
      N_ADD: begin
        o_alu_sel     = ALU_f_ADD;
        o_flag_rule   = FLAG_CARRY;
        o_writes_flag = 1'b1;
      end
      N_SUB: begin
        o_alu_sel     = ALU_f_MINUS;
        o_flag_rule   = FLAG_NO_BORROW;
        o_writes_flag = 1'b1;
      end
      N_SUBN: begin
        o_alu_sel       = ALU_f_MINUS;
        o_swap_operands = 1'b1;
        o_flag_rule     = FLAG_NO_BORROW;
        o_writes_flag   = 1'b1;
      end
      N_SHR: begin
        o_alu_sel      = ALU_f_RSHIFT;
        o_in2_is_const = 1'b1;
        o_in2_const    = 8'h01;
        o_flag_rule    = FLAG_VX_LSB;
        o_writes_flag  = 1'b1;
      end
      N_SHL: begin
        o_alu_sel      = ALU_f_LSHIFT;
        o_in2_is_const = 1'b1;
        o_in2_const    = 8'h01;
        o_flag_rule    = FLAG_VX_MSB;
        o_writes_flag  = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/chip8_alu_sequencer.sv
// chip8_alu_sequencer
// Executes one CHIP-8 8XYN instruction: reads Vx and Vy, runs the ALU,
// writes Vx and then (for flag ops) VF.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; aborts any instruction in flight
//   io_bus - chip8_alu_sequencer_if.master (CPU, V-register and ALU buses)
// Parameter FLAG_REG: V-register index receiving the flag.
// Build option: CHIP8_VF_RESET_EN (see chip8_alu_op_decode).
//
// state  | meaning
// IDLE   | waiting for start; latches opcode fields
// RD_X   | address Vx
// RD_Y   | address Vy, capture Vx
// EXEC   | Vy on read bus, drive ALU, capture result and flag
// WB_X   | write result to Vx
// WB_F   | write flag to FLAG_REG (flag ops only, last so it wins if X==F)
// DONE   | one-cycle done pulse (illegal qualified here)
module chip8_alu_sequencer
  import chip8_alu_sequencer_pkg::*;
#(
  parameter logic [3:0] FLAG_REG = 4'hF
) (
  input  logic                    clk,
  input  logic                    reset,
  chip8_alu_sequencer_if.master   io_bus
);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [3:0] r_op;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic       r_illegal;
  logic [7:0] r_vx;
  logic [7:0] r_res;
  logic       r_flag;

  logic [3:0]  w_dec_n;
  ALU_f        w_alu_sel;
  logic        w_swap;
  logic        w_in2_is_const;
  logic [7:0]  w_in2_const;
  flag_rule_t  w_flag_rule;
  logic        w_writes_flag;
  logic        w_illegal;
  logic [15:0] w_in1;
  logic [15:0] w_in2;
  logic        w_unused_bits;

  // In IDLE the legality decision must come from the live opcode; afterwards
  // from the latched copy.
  assign w_dec_n = (r_state == S_IDLE) ? io_bus.opcode_n : r_op;

  chip8_alu_op_decode u_decode (
    .i_n             (w_dec_n),
    .o_alu_sel       (w_alu_sel),
    .o_swap_operands (w_swap),
    .o_in2_is_const  (w_in2_is_const),
    .o_in2_const     (w_in2_const),
    .o_flag_rule     (w_flag_rule),
    .o_writes_flag   (w_writes_flag),
    .o_illegal       (w_illegal)
  );

  // In EXEC reg_rdata carries Vy.
  assign w_in1 = w_swap ? {8'h00, io_bus.reg_rdata} : {8'h00, r_vx};
  assign w_in2 = w_in2_is_const ? {8'h00, w_in2_const} :
                 w_swap         ? {8'h00, r_vx} : {8'h00, io_bus.reg_rdata};

  assign w_unused_bits = &{1'b0, io_bus.alu_carry, io_bus.alu_out[14:9]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (io_bus.start) w_next_state = w_illegal ? S_DONE : S_RD_X;
      S_RD_X:  w_next_state = S_RD_Y;
      S_RD_Y:  w_next_state = S_EXEC;
      S_EXEC:  w_next_state = S_WB_X;
      S_WB_X:  w_next_state = w_writes_flag ? S_WB_F : S_DONE;
      S_WB_F:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // All outputs are forced to their idle values while reset is high so no
  // write can escape in the reset cycle.
  always_comb begin
    io_bus.busy      = 1'b0;
    io_bus.done      = 1'b0;
    io_bus.illegal   = 1'b0;
    io_bus.reg_addr  = 4'h0;
    io_bus.reg_we    = 1'b0;
    io_bus.reg_wdata = 8'h00;
    io_bus.alu_in1   = 16'h0000;
    io_bus.alu_in2   = 16'h0000;
    io_bus.alu_sel   = ALU_f_OR;
    if (!reset) begin
      io_bus.busy = (r_state != S_IDLE);
      case (r_state)
        S_RD_X: io_bus.reg_addr = r_x;
        S_RD_Y: io_bus.reg_addr = r_y;
        S_EXEC: begin
          io_bus.alu_in1 = w_in1;
          io_bus.alu_in2 = w_in2;
          io_bus.alu_sel = w_alu_sel;
        end
        S_WB_X: begin
          io_bus.reg_we    = 1'b1;
          io_bus.reg_addr  = r_x;
          io_bus.reg_wdata = r_res;
        end
        S_WB_F: begin
          io_bus.reg_we    = 1'b1;
          io_bus.reg_addr  = FLAG_REG;
          io_bus.reg_wdata = {7'b0, r_flag};
        end
        S_DONE: begin
          io_bus.done    = 1'b1;
          io_bus.illegal = r_illegal;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= 4'h0;
      r_x       <= 4'h0;
      r_y       <= 4'h0;
      r_illegal <= 1'b0;
      r_vx      <= 8'h00;
      r_res     <= 8'h00;
      r_flag    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.start) begin
          r_op      <= io_bus.opcode_n;
          r_x       <= io_bus.x_idx;
          r_y       <= io_bus.y_idx;
          r_illegal <= w_illegal;
        end
        S_RD_Y: r_vx <= io_bus.reg_rdata;
        S_EXEC: begin
          r_res  <= io_bus.alu_out[7:0];
          r_flag <= calc_flag(w_flag_rule, io_bus.alu_out, r_vx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
module tb_chip8_alu_sequencer;
  import chip8_alu_sequencer_pkg::*;

`ifdef CHIP8_VF_RESET_EN
  localparam int         LAT_LOGIC = 6;
  localparam int         NW_LOGIC  = 2;
  localparam logic [7:0] VF_LOGIC  = 8'h00;
`else
  localparam int         LAT_LOGIC = 5;
  localparam int         NW_LOGIC  = 1;
  localparam logic [7:0] VF_LOGIC  = 8'h77;
`endif

  typedef struct {
    logic [3:0] n, x, y;
    logic [7:0] vx, vy, vf;
    logic [7:0] exp_x, exp_f;
    int         lat;
    bit         ill;
    int         nw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  chip8_alu_sequencer_if io();

  chip8_alu_sequencer #(.FLAG_REG(4'hF)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (io)
  );

  // V-register file model with one-cycle read latency, plus a preload port
  logic [7:0] regs [16];
  logic       pre_we;
  logic [3:0] pre_addr;
  logic [7:0] pre_data;
  int         wr_count = 0;
  logic [3:0] wr_addr [256];
  logic [7:0] wr_data [256];

  always @(posedge clk) begin
    if (io.reg_we) begin
      regs[io.reg_addr]        <= io.reg_wdata;
      wr_addr[wr_count[7:0]]   <= io.reg_addr;
      wr_data[wr_count[7:0]]   <= io.reg_wdata;
      wr_count                 <= wr_count + 1;
    end else if (pre_we) begin
      regs[pre_addr] <= pre_data;
    end
    io.reg_rdata <= regs[io.reg_addr];
  end

  // ALU model
  always_comb begin
    io.alu_carry = 1'b0;
    case (io.alu_sel)
      ALU_f_OR:     io.alu_out = io.alu_in1 | io.alu_in2;
      ALU_f_AND:    io.alu_out = io.alu_in1 & io.alu_in2;
      ALU_f_XOR:    io.alu_out = io.alu_in1 ^ io.alu_in2;
      ALU_f_ADD:    io.alu_out = io.alu_in1 + io.alu_in2;
      ALU_f_MINUS:  io.alu_out = io.alu_in1 - io.alu_in2;
      ALU_f_RSHIFT: io.alu_out = io.alu_in1 >> io.alu_in2[3:0];
      ALU_f_LSHIFT: io.alu_out = io.alu_in1 << io.alu_in2[3:0];
      default:      io.alu_out = 16'h0000;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Launches one instruction; lat counts the start cycle as 0, -1 on timeout.
  task automatic run_op(input logic [3:0] n, input logic [3:0] x, input logic [3:0] y,
                        output int lat, output logic ill, output int nw, output int w0);
    @(negedge clk);
    io.opcode_n = n; io.x_idx = x; io.y_idx = y; io.start = 1'b1;
    w0 = wr_count; lat = -1; ill = 1'b0;
    @(posedge clk);
    #1 io.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (io.done) begin
        lat = k; ill = io.illegal;
        break;
      end
    end
    @(negedge clk);
    nw = wr_count - w0;
  endtask

  vec_t vecs[$];

  initial begin
    int lat, nw, w0;
    logic ill;
    string nm;

    vecs.push_back('{4'h4, 4'h1, 4'h2, 8'hF0, 8'h20, 8'h55, 8'h10, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'h5, 4'h1, 4'h2, 8'h05, 8'h07, 8'h55, 8'hFE, 8'h00, 6, 1'b0, 2});
    vecs.push_back('{4'h5, 4'h1, 4'h2, 8'h07, 8'h07, 8'h55, 8'h00, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'h6, 4'h1, 4'h1, 8'h03, 8'h03, 8'h55, 8'h01, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'hE, 4'h1, 4'h1, 8'h81, 8'h81, 8'h55, 8'h02, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'h4, 4'hF, 4'h2, 8'hF0, 8'h20, 8'hF0, 8'h01, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'h8, 4'h1, 4'h2, 8'hAA, 8'hBB, 8'h77, 8'hAA, 8'h77, 1, 1'b1, 0});
    vecs.push_back('{4'h1, 4'h1, 4'h2, 8'h0C, 8'h03, 8'h77, 8'h0F, VF_LOGIC, LAT_LOGIC, 1'b0, NW_LOGIC});
    vecs.push_back('{4'h0, 4'h1, 4'h2, 8'h11, 8'h5A, 8'h77, 8'h5A, 8'h77, 5, 1'b0, 1});
    vecs.push_back('{4'h2, 4'h1, 4'h2, 8'hF0, 8'h3C, 8'h77, 8'h30, VF_LOGIC, LAT_LOGIC, 1'b0, NW_LOGIC});
    vecs.push_back('{4'h3, 4'h1, 4'h2, 8'hF0, 8'h3C, 8'h77, 8'hCC, VF_LOGIC, LAT_LOGIC, 1'b0, NW_LOGIC});
    vecs.push_back('{4'h7, 4'h3, 4'h4, 8'h10, 8'h30, 8'h55, 8'h20, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'h7, 4'h3, 4'h4, 8'h30, 8'h10, 8'h55, 8'hE0, 8'h00, 6, 1'b0, 2});
    vecs.push_back('{4'h6, 4'h1, 4'h2, 8'h80, 8'h00, 8'h55, 8'h40, 8'h00, 6, 1'b0, 2});
    vecs.push_back('{4'hE, 4'h1, 4'h2, 8'h40, 8'h00, 8'h55, 8'h80, 8'h00, 6, 1'b0, 2});
    vecs.push_back('{4'h4, 4'h1, 4'h2, 8'hFF, 8'h01, 8'h55, 8'h00, 8'h01, 6, 1'b0, 2});
    vecs.push_back('{4'hF, 4'h1, 4'h2, 8'hAA, 8'hBB, 8'h77, 8'hAA, 8'h77, 1, 1'b1, 0});
    vecs.push_back('{4'hD, 4'h1, 4'h2, 8'hAA, 8'hBB, 8'h77, 8'hAA, 8'h77, 1, 1'b1, 0});

    reset = 1'b1; pre_we = 1'b0; pre_addr = 4'h0; pre_data = 8'h00;
    io.start = 1'b0; io.opcode_n = 4'h0; io.x_idx = 4'h0; io.y_idx = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy",    {31'b0, io.busy},    32'h0);
    chk("rst_done",    {31'b0, io.done},    32'h0);
    chk("rst_illegal", {31'b0, io.illegal}, 32'h0);
    chk("rst_we",      {31'b0, io.reg_we},  32'h0);
    chk("rst_addr",    {28'b0, io.reg_addr}, 32'h0);
    chk("rst_wdata",   {24'b0, io.reg_wdata}, 32'h0);
    chk("rst_in1",     {16'b0, io.alu_in1}, 32'h0);
    chk("rst_in2",     {16'b0, io.alu_in2}, 32'h0);
    chk("rst_sel",     {29'b0, io.alu_sel}, {29'b0, ALU_f_OR});

    foreach (vecs[i]) begin
      preload(4'hF, vecs[i].vf);
      preload(vecs[i].y, vecs[i].vy);
      preload(vecs[i].x, vecs[i].vx);
      run_op(vecs[i].n, vecs[i].x, vecs[i].y, lat, ill, nw, w0);
      nm = $sformatf("v%0d_N%0h", i, vecs[i].n);
      chk({nm, "_lat"}, lat, vecs[i].lat);
      chk({nm, "_ill"}, {31'b0, ill}, {31'b0, vecs[i].ill});
      chk({nm, "_nwr"}, nw, vecs[i].nw);
      chk({nm, "_vx"},  {24'b0, regs[vecs[i].x]}, {24'b0, vecs[i].exp_x});
      chk({nm, "_vf"},  {24'b0, regs[4'hF]},      {24'b0, vecs[i].exp_f});
    end

    // 8124: result to V1 then flag to VF
    preload(4'hF, 8'h55); preload(4'h2, 8'h20); preload(4'h1, 8'hF0);
    run_op(4'h4, 4'h1, 4'h2, lat, ill, nw, w0);
    chk("ord_n",     nw, 2);
    chk("ord_a0",    {28'b0, wr_addr[w0[7:0]]},       32'h1);
    chk("ord_d0",    {24'b0, wr_data[w0[7:0]]},       32'h10);
    chk("ord_a1",    {28'b0, wr_addr[w0[7:0] + 8'd1]}, 32'hF);
    chk("ord_d1",    {24'b0, wr_data[w0[7:0] + 8'd1]}, 32'h01);

    // 8F24: result write to VF precedes the overriding flag write
    preload(4'hF, 8'hF0); preload(4'h2, 8'h20);
    run_op(4'h4, 4'hF, 4'h2, lat, ill, nw, w0);
    chk("xf_a0", {28'b0, wr_addr[w0[7:0]]},       32'hF);
    chk("xf_d0", {24'b0, wr_data[w0[7:0]]},       32'h10);
    chk("xf_a1", {28'b0, wr_addr[w0[7:0] + 8'd1]}, 32'hF);
    chk("xf_d1", {24'b0, wr_data[w0[7:0] + 8'd1]}, 32'h01);

    // start while busy is ignored
    preload(4'hF, 8'h55); preload(4'h2, 8'h20); preload(4'h1, 8'hF0);
    @(negedge clk);
    io.opcode_n = 4'h4; io.x_idx = 4'h1; io.y_idx = 4'h2; io.start = 1'b1;
    w0 = wr_count;
    @(posedge clk); #1 io.start = 1'b0;
    @(negedge clk);
    io.opcode_n = 4'h1; io.x_idx = 4'h3; io.start = 1'b1;
    @(posedge clk); #1 io.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_start_nwr", wr_count - w0, 2);
    chk("busy_start_v1",  {24'b0, regs[4'h1]}, 32'h10);
    chk("busy_start_idle", {31'b0, io.busy}, 32'h0);

    // reset during EXEC of 8124 aborts with no writes
    preload(4'hF, 8'h55); preload(4'h2, 8'h20); preload(4'h1, 8'hF0);
    @(negedge clk);
    io.opcode_n = 4'h4; io.x_idx = 4'h1; io.y_idx = 4'h2; io.start = 1'b1;
    w0 = wr_count;
    @(posedge clk); #1 io.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_exec_sel", {29'b0, io.alu_sel}, {29'b0, ALU_f_ADD});
    chk("abort_exec_in1", {16'b0, io.alu_in1}, 32'hF0);
    reset = 1'b1;
    #1 chk("abort_we_rst", {31'b0, io.reg_we}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, io.busy}, 32'h0);
    repeat (8) @(negedge clk);
    chk("abort_nwr", wr_count - w0, 0);
    chk("abort_v1",  {24'b0, regs[4'h1]}, 32'hF0);
    chk("abort_vf",  {24'b0, regs[4'hF]}, 32'h55);
    run_op(4'h4, 4'h1, 4'h2, lat, ill, nw, w0);
    chk("after_lat", lat, 6);
    chk("after_v1",  {24'b0, regs[4'h1]}, 32'h10);
    chk("after_vf",  {24'b0, regs[4'hF]}, 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chip8_alu_sequencer.md
Name: chip8_alu_sequencer

Overview:
Multi-cycle controller that executes CHIP-8 8XYN register-arithmetic instructions on behalf of the CPU.
- Fetches Vx/Vy from the V-register file, drives the Chip8 ALU, and writes back Vx and then VF.
- Derives the VF flag from the 16-bit ALU result, not from alu_carry.
- Sits between the CPU decode stage, the V-register file and the ALU. The CPU hands over an opcode with a start pulse and waits for done.

Parameters:
- FLAG_REG, 4'hF, V-register index written with the flag.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- opcode_n  in  4  N nibble of 8XYN
- x_idx  in  4  X nibble
- y_idx  in  4  Y nibble
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; N not in {0-7,E}
- reg_addr  out  4  V-register read/write address
- reg_rdata  in  8  read data, valid one cycle after reg_addr
- reg_we  out  1  write strobe
- reg_wdata  out  8  write data
- alu_in1  out  16  ALU operand 1, zero-extended byte
- alu_in2  out  16  ALU operand 2
- alu_sel  out  ALU_f  ALU function select
- alu_out  in  16  ALU result
- alu_carry  in  1  unused; present for interface completeness

Behaviour:
- Reset values: busy=0, done=0, illegal=0, reg_we=0, reg_addr=0, reg_wdata=0, alu_in1=0, alu_in2=0, alu_sel=ALU_f_OR. FSM returns to IDLE.
- Reset mid-operation aborts the instruction. No write is issued in the cycle reset is high or afterward. busy=0 the cycle after reset.
- States: IDLE -> RD_X -> RD_Y -> EXEC -> WB_X -> [WB_F] -> DONE -> IDLE.
- IDLE: on start, latch opcode_n/x_idx/y_idx.
  - If illegal, go directly to DONE with illegal=1; no reads or writes.
- RD_X: reg_addr=X.
- RD_Y: reg_addr=Y; latch vx_q<=reg_rdata.
- EXEC: drive the ALU combinationally from vx_q and reg_rdata (=Vy). Latch res_q<=alu_out[7:0] and flag_q.
- Op mapping (in1, in2, sel -> flag):
  - 0: Vy, 0, OR; no flag.
  - 1: Vx, Vy, OR; no flag.
  - 2: Vx, Vy, AND; no flag.
  - 3: Vx, Vy, XOR; no flag.
  - 4: Vx, Vy, ADD; flag=alu_out[8].
  - 5: Vx, Vy, MINUS; flag=~alu_out[15] (1 = no borrow, Vx>=Vy).
  - 7: Vy, Vx, MINUS; flag=~alu_out[15].
  - 6: Vx, 1, RSHIFT; flag=Vx[0].
  - E: Vx, 1, LSHIFT; flag=Vx[7].
- Result truncation: 8 bits, so wrap-around is modulo 256.
- WB_X: reg_we=1, reg_addr=X, reg_wdata=res_q.
- WB_F: reg_we=1, reg_addr=FLAG_REG, reg_wdata={7'b0,flag_q}.
  - Entered only for flag-writing ops.
  - When X==F the flag write occurs last and overrides the result.
- DONE: done=1 for one cycle, then IDLE.
- Latency, counting the start cycle as 0: done at cycle 6 for flag ops, 5 for no-flag ops, 1 for illegal.
- start while busy is ignored; no queueing.
- At most one reg_we per cycle. reg_we is never asserted outside WB_X/WB_F.

Optional Feature:
- Macro CHIP8_VF_RESET_EN.
- Defined: ops 1, 2 and 3 also visit WB_F writing VF=0 (COSMAC quirk); latency 6.
- Undefined: ops 1/2/3 leave VF untouched; latency 5.

Decomposition:
- enums.svh gains:
  - seq_state_t enum for the FSM states.
  - Constants for the N codes: N_LD=0, N_OR=1, N_AND=2, N_XOR=3, N_ADD=4, N_SUB=5, N_SHR=6, N_SUBN=7, N_SHL=E.
  - Existing ALU_f is reused.
- One combinational sub-module, chip8_alu_op_decode.
  - Input: N.
  - Outputs: alu_sel, swap_operands, in2_is_const (constant value), flag_rule, writes_flag, illegal.

Test Plan:
- V1=F0, V2=20, 8124 -> V1=10, VF=01; done at cycle 6; exactly two reg_we pulses (addr 1, then F).
- V1=05, V2=07, 8125 -> V1=FE, VF=00. Then V1=07, V2=07, 8125 -> V1=00, VF=01.
- V1=03: 8116 -> V1=01, VF=01. Then V1=81: 811E -> V1=02, VF=01.
- VF=F0, V2=20, 8F24 -> final VF=01; the result write (10) precedes the flag write.
- 8128 -> done+illegal at cycle 1; reg_we never asserted. Then 8121 with V1=0C, V2=03 -> V1=0F, VF unchanged (macro off) or 00 (macro on).
- Assert reset during EXEC of 8124 -> no reg_we, busy=0 next cycle. A fresh start then completes normally.
